// File: rtl/multi_timer_if.sv
// Host-side bus of the multi-channel timer: prescaler setting, reload
// load port, per-channel control vectors and the channel status outputs.
// TIMER_CASCADE_EN adds the per-channel cascade select vector.
interface multi_timer_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRESC_W-1:0]      prescale;
  logic                    ld_en;
  logic [CH_W-1:0]         ld_ch;
  logic [CNT_W-1:0]        ld_val;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH-1:0]       irq_clr;
`ifdef TIMER_CASCADE_EN
  logic [NUM_CH-1:0]       cascade;
`endif
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH-1:0]       timeout;
  logic [NUM_CH-1:0]       irq_flag;
  logic [NUM_CH*CNT_W-1:0] count;

`ifdef TIMER_CASCADE_EN
  modport master (
    output prescale, ld_en, ld_ch, ld_val, start, stop, periodic, irq_clr, cascade,
    input  running, timeout, irq_flag, count
  );
  modport slave (
    input  prescale, ld_en, ld_ch, ld_val, start, stop, periodic, irq_clr, cascade,
    output running, timeout, irq_flag, count
  );
`else
  modport master (
    output prescale, ld_en, ld_ch, ld_val, start, stop, periodic, irq_clr,
    input  running, timeout, irq_flag, count
  );
  modport slave (
    input  prescale, ld_en, ld_ch, ld_val, start, stop, periodic, irq_clr,
    output running, timeout, irq_flag, count
  );
`endif
endinterface

// File: rtl/multi_timer.sv
// Multi-channel programmable down-counter timer.
// All channels share one prescaler tick; each channel has its own reload
// register, one-shot/periodic mode, a registered one-cycle timeout pulse
// and a sticky interrupt flag. Per-channel priority: stop > start > tick.
// Optional build macro TIMER_CASCADE_EN: channel i>0 with cascade[i]=1
// counts on timeout[i-1] instead of the prescaler tick (chained counts).
module multi_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  multi_timer_if.slave  tmr_if
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;
  logic [NUM_CH-1:0]  ch_tick;

  ch_state_e          state_q  [NUM_CH];
  ch_state_e          state_d  [NUM_CH];
  logic [CNT_W-1:0]   cnt_q    [NUM_CH];
  logic [CNT_W-1:0]   cnt_d    [NUM_CH];
  logic [CNT_W-1:0]   reload_q [NUM_CH];
  logic [CNT_W-1:0]   reload_d [NUM_CH];
  logic [NUM_CH-1:0]  timeout_q, timeout_d;
  logic [NUM_CH-1:0]  irq_q, irq_d;

  // Shared prescaler: compare against the live prescale value so a change
  // takes effect at the current compare without producing extra ticks.
  always_comb begin
    tick    = (presc_q >= tmr_if.prescale);
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  // Per-channel count enable: prescaler tick, or the previous channel's
  // timeout pulse when cascading is built in and selected.
`ifdef TIMER_CASCADE_EN
  logic unused_cascade0;
  assign unused_cascade0 = tmr_if.cascade[0];

  always_comb begin
    ch_tick[0] = tick;
    for (int i = 1; i < NUM_CH; i++) begin
      ch_tick[i] = tmr_if.cascade[i] ? timeout_q[i-1] : tick;
    end
  end
`else
  always_comb begin
    ch_tick = {NUM_CH{tick}};
  end
`endif

  // Channel next-state: stop > start > tick, expiry handling, sticky flag
  // and reload-register load. The periodic reload reads reload_q, so a load
  // landing in the same cycle only affects the following period.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    timeout_d = '0;
    irq_d     = irq_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tmr_if.stop[i]) begin
        state_d[i] = CH_IDLE;
      end else if (tmr_if.start[i]) begin
        cnt_d[i]   = reload_q[i];
        state_d[i] = CH_RUN;
      end else if (state_q[i] == CH_RUN && ch_tick[i]) begin
        if (cnt_q[i] == '0) begin
          timeout_d[i] = 1'b1;
          if (tmr_if.periodic[i]) begin
            cnt_d[i] = reload_q[i];
          end else begin
            state_d[i] = CH_IDLE;
          end
        end else begin
          // Expiry is caught at zero, so this never wraps.
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end

      // A new expiry wins over a clear in the same cycle.
      if (timeout_d[i]) begin
        irq_d[i] = 1'b1;
      end else if (tmr_if.irq_clr[i]) begin
        irq_d[i] = 1'b0;
      end

      // Out-of-range channel indices never match, so they are ignored.
      if (tmr_if.ld_en && tmr_if.ld_ch == CH_W'(i)) begin
        reload_d[i] = tmr_if.ld_val;
      end
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= CH_IDLE;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block evaluation order.
      state_q <= state_d;
    end
  end

  // Datapath registers: prescaler, counters, reload values and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      timeout_q <= '0;
      irq_q     <= '0;
      // NOTE: the reload bank is reset (flops, not RAM) because a start
      // issued before any load must count from a defined value of 0.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
    end
  end

  // Status outputs straight from registers.
  always_comb begin
    tmr_if.timeout  = timeout_q;
    tmr_if.irq_flag = irq_q;
    for (int i = 0; i < NUM_CH; i++) begin
      tmr_if.running[i]                = (state_q[i] == CH_RUN);
      tmr_if.count[i*CNT_W +: CNT_W]   = cnt_q[i];
    end
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Multi-channel programmable down-counter timer; successor to the single-channel start/timeout timer.
- Each channel has:
  - its own reload value
  - one-shot or periodic mode
  - a one-cycle timeout pulse
  - a sticky interrupt flag
- All channels share one prescaler tick. The block sits on the CPU peripheral side and is driven by control logic through a load port and start/stop vectors.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- CNT_W, 32, width of each channel counter and reload register.
- PRESC_W, 8, width of the shared prescaler compare value.
- CH_W, max(1, clog2(NUM_CH)), local, width of the channel index.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prescale  in  PRESC_W  tick divider: one tick every prescale+1 clk cycles.
- ld_en  in  1  write ld_val into the reload register of channel ld_ch.
- ld_ch  in  CH_W  channel index for load.
- ld_val  in  CNT_W  reload value.
- start  in  NUM_CH  per-channel start/restart pulse.
- stop  in  NUM_CH  per-channel stop pulse.
- periodic  in  NUM_CH  1 = auto-reload on expiry, 0 = one-shot. Sampled at every expiry.
- irq_clr  in  NUM_CH  per-channel clear of irq_flag.
- running  out  NUM_CH  channel is counting.
- timeout  out  NUM_CH  one-cycle expiry pulse, registered.
- irq_flag  out  NUM_CH  sticky expiry flag.
- count  out  NUM_CH*CNT_W  current counters, channel i at bits [i*CNT_W +: CNT_W].

Behaviour:
- **Reset (rst_n low, asynchronous, no clock needed):**
  - prescaler counter, all counts, all reload registers, running, timeout and irq_flag go to 0.
  - Reset mid-count abandons the count; no timeout is generated.
- **Prescaler:**
  - presc_cnt is free-running from reset.
  - If presc_cnt >= prescale: tick = 1 and presc_cnt <= 0; else presc_cnt increments.
  - prescale = 0 gives a tick every cycle.
  - Changing prescale mid-run takes effect at the current compare; no glitch ticks.
- **Load:**
  - ld_en writes reload[ld_ch] only.
  - The current count is unaffected; the new value applies at the next start or periodic reload.
  - ld_ch >= NUM_CH is ignored.
- **Channel states:** IDLE (running = 0) and RUN (running = 1). Per-channel priority each cycle is stop > start > tick.
  - stop: go to IDLE; count holds its value; no timeout.
  - start (any state): count <= reload, go to RUN, visible the next cycle. Restarting a running channel reloads it.
  - tick in RUN with count != 0: count <= count - 1.
  - tick in RUN with count == 0:
    - timeout[i] <= 1 for exactly one cycle, and irq_flag[i] <= 1.
    - If periodic[i]: count <= reload, stay in RUN.
    - Else: go to IDLE, count stays 0.
  - A load of reload[i] in the same cycle as a periodic reload of channel i: the periodic reload uses the old value.
- **Timing:**
  - Expiry period is (reload+1) ticks = (reload+1)*(prescale+1) cycles.
  - reload = 0 expires on the first tick.
  - With prescale = 0, timeout is high in cycle S+reload+1, where S is the first cycle with running = 1.
- **irq_flag:** set has priority over irq_clr in the same cycle; otherwise irq_clr clears it.
- **Arithmetic:** counters are unsigned CNT_W. The decrement never wraps, because expiry is detected at 0.

Optional Feature:
- Macro TIMER_CASCADE_EN.
- **Defined:**
  - Adds input port cascade [NUM_CH].
  - For i > 0 with cascade[i] = 1, channel i decrements on timeout[i-1] instead of the prescaler tick. This gives chained wide counts.
  - cascade[0] is ignored.
- **Undefined:** the port is absent and every channel uses the prescaler tick.

Test Plan:
- **One-shot:** prescale=0, load ch0=3, start[0] pulse → running[0]=1 with count0=3 next cycle; timeout[0] high one cycle at S+4; running[0]=0 in that same cycle; irq_flag[0]=1.
- **Periodic:** prescale=0, ch1 reload=2, periodic[1]=1, start → timeout[1] pulses every 3 cycles (4 pulses in 12 cycles); running[1] stays 1.
- **Prescaler:** prescale=3, ch2 reload=1, periodic → timeout[2] pulses spaced exactly 8 cycles apart.
- **Priority:**
  - start[0] and stop[0] in the same cycle → running[0]=0.
  - stop mid-count at count=5 → count holds at 5, no timeout.
  - ld_en to ch0 while it runs → current period unchanged, next reload uses the new value.
- **Flags:** irq_clr[1] asserted in the same cycle as an expiry → irq_flag[1]=1; irq_clr[1] the next cycle → 0.
- **Reset:** drive rst_n low mid-run between clock edges → running, count, timeout and irq_flag go to 0 immediately. After release with no start, no timeout occurs for 50 cycles.
